// File: rtl/key_pulse_conditioner.sv
// Push-button conditioner: 2-flop synchronizer, debounce/hold FSM and registered
// press, long-press and level outputs for the downstream toggle selector.
module key_pulse_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LONG_CYCLES     = 8,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic pulse,
    output logic long_pulse,
    output logic key_level
);

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        LONG_HELD,
        RELEASE_WAIT
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             s1;
    logic             key_s;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] hold;
    logic [CNT_W-1:0] hold_next;
    logic             long_seen;
    logic             long_seen_next;
    logic             pulse_next;
    logic             long_next;
    logic             level_next;

    // Synchronizer stage: key_raw is asynchronous, only key_s feeds the FSM
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1    <= 1'b0;
            key_s <= 1'b0;
        end else begin
            s1    <= key_raw;
            key_s <= s1;
        end
    end

    // FSM stage: state, counters and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            hold       <= '0;
            long_seen  <= 1'b0;
            pulse      <= 1'b0;
            long_pulse <= 1'b0;
            key_level  <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            hold       <= hold_next;
            long_seen  <= long_seen_next;
            pulse      <= pulse_next;
            long_pulse <= long_next;
            key_level  <= level_next;
        end
    end

    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        hold_next      = hold;
        long_seen_next = long_seen;
        case (state)
            IDLE: begin
                if (key_s) begin
                    state_next = PRESS_WAIT;
                    cnt_next   = CNT_ONE;
                end
            end
            PRESS_WAIT: begin
                if (!key_s) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == DB_LAST) begin
                    state_next     = PRESSED;
                    hold_next      = '0;
                    long_seen_next = 1'b0;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!key_s) begin
                    state_next = RELEASE_WAIT;
                    cnt_next   = CNT_ONE;
                end else if ((hold == LONG_LAST) && !long_seen) begin
                    state_next     = LONG_HELD;
                    long_seen_next = 1'b1;
                end else if (hold != LONG_LAST) begin
                    hold_next = hold + CNT_ONE;
                end
            end
            LONG_HELD: begin
                if (!key_s) begin
                    state_next = RELEASE_WAIT;
                    cnt_next   = CNT_ONE;
                end
            end
            RELEASE_WAIT: begin
                // A short low while held is a glitch: resume without restarting hold
                if (key_s) begin
                    state_next = long_seen ? LONG_HELD : PRESSED;
                end else if (cnt == DB_LAST) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        pulse_next = (state == PRESS_WAIT) && (state_next == PRESSED);
        long_next  = (state == PRESSED) && (state_next == LONG_HELD);
        level_next = (state_next == PRESSED) || (state_next == LONG_HELD) ||
                     (state_next == RELEASE_WAIT);
    end

endmodule

// File: tb/tb_key_pulse_conditioner.sv
// Bench for key_pulse_conditioner: per-cycle expected {pulse, long_pulse, key_level}
// queued at drive time and compared one cycle-sample later.
module tb_key_pulse_conditioner;

    logic clk;
    logic rst;
    logic key_raw;
    logic pulse;
    logic long_pulse;
    logic key_level;

    key_pulse_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES(8),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .key_raw(key_raw),
        .pulse(pulse),
        .long_pulse(long_pulse),
        .key_level(key_level)
    );

    typedef struct {
        logic       rst_v;
        logic       key_v;
        int         n;
        logic [2:0] exp;   // {pulse, long_pulse, key_level}
        string      name;
    } vec_t;

    vec_t       vecs[$];
    logic [2:0] sb[$];
    int         tests;
    int         fails;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic r, input logic k, input int n, input logic [2:0] e,
                        input string name);
        logic [2:0] got;
        logic [2:0] want;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst     = r;
            key_raw = k;
            sb.push_back(e);
            @(posedge clk);
            #1;
            got  = {pulse, long_pulse, key_level};
            want = sb.pop_front();
            tests++;
            if (got !== want) begin
                fails++;
                $display("FAIL %s cycle %0d: got p/l/lvl=%b expected %b", name, i, got, want);
            end
        end
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        rst     = 1'b0;
        key_raw = 1'b0;

        // Reset and idle
        vecs.push_back('{1'b0, 1'b0, 3,  3'b000, "reset"});
        vecs.push_back('{1'b1, 1'b0, 20, 3'b000, "idle"});
        // Clean press: pulse after E5, level falls at R0+5
        vecs.push_back('{1'b1, 1'b1, 5,  3'b000, "clean_wait"});
        vecs.push_back('{1'b1, 1'b1, 1,  3'b101, "clean_pulse"});
        vecs.push_back('{1'b1, 1'b0, 5,  3'b001, "clean_rel_wait"});
        vecs.push_back('{1'b1, 1'b0, 4,  3'b000, "clean_released"});
        // Bounce 1,1,0,1,1,1,0 then steady 1
        vecs.push_back('{1'b1, 1'b1, 2,  3'b000, "bounce_a"});
        vecs.push_back('{1'b1, 1'b0, 1,  3'b000, "bounce_b"});
        vecs.push_back('{1'b1, 1'b1, 3,  3'b000, "bounce_c"});
        vecs.push_back('{1'b1, 1'b0, 1,  3'b000, "bounce_d"});
        vecs.push_back('{1'b1, 1'b1, 5,  3'b000, "bounce_settle"});
        vecs.push_back('{1'b1, 1'b1, 1,  3'b101, "bounce_pulse"});
        vecs.push_back('{1'b1, 1'b0, 5,  3'b001, "bounce_rel_wait"});
        vecs.push_back('{1'b1, 1'b0, 4,  3'b000, "bounce_released"});
        // Long hold of 30 cycles
        vecs.push_back('{1'b1, 1'b1, 5,  3'b000, "long_wait"});
        vecs.push_back('{1'b1, 1'b1, 1,  3'b101, "long_pulse_short"});
        vecs.push_back('{1'b1, 1'b1, 7,  3'b001, "long_hold"});
        vecs.push_back('{1'b1, 1'b1, 1,  3'b011, "long_strobe"});
        vecs.push_back('{1'b1, 1'b1, 16, 3'b001, "long_after"});
        vecs.push_back('{1'b1, 1'b0, 5,  3'b001, "long_rel_wait"});
        vecs.push_back('{1'b1, 1'b0, 4,  3'b000, "long_released"});

        foreach (vecs[i])
            step(vecs[i].rst_v, vecs[i].key_v, vecs[i].n, vecs[i].exp, vecs[i].name);

        // Release glitch in PRESSED delays long press by the frozen-hold cycles
        step(1'b1, 1'b1, 5, 3'b000, "glitch_wait");
        step(1'b1, 1'b1, 1, 3'b101, "glitch_pulse");
        step(1'b1, 1'b1, 1, 3'b001, "glitch_pre");
        step(1'b1, 1'b0, 1, 3'b001, "glitch_low");
        step(1'b1, 1'b1, 7, 3'b001, "glitch_resume");
        step(1'b1, 1'b1, 1, 3'b011, "glitch_long");
        step(1'b1, 1'b1, 2, 3'b001, "glitch_held");
        // Glitch after long press must not refire long_pulse
        step(1'b1, 1'b0, 1, 3'b001, "glitch2_low");
        step(1'b1, 1'b1, 5, 3'b001, "glitch2_resume");
        step(1'b1, 1'b0, 5, 3'b001, "glitch2_rel_wait");
        step(1'b1, 1'b0, 4, 3'b000, "glitch2_released");

        // Reset in PRESS_WAIT with cnt=2, key held across reset
        step(1'b1, 1'b1, 4, 3'b000, "rstpw_wait");
        step(1'b0, 1'b1, 2, 3'b000, "rstpw_reset");
        step(1'b1, 1'b1, 5, 3'b000, "rstpw_restart");
        step(1'b1, 1'b1, 1, 3'b101, "rstpw_pulse");
        step(1'b1, 1'b0, 5, 3'b001, "rstpw_rel_wait");
        step(1'b1, 1'b0, 4, 3'b000, "rstpw_released");

        // Reset while PRESSED clears the level and restarts debounce
        step(1'b1, 1'b1, 5, 3'b000, "rstpr_wait");
        step(1'b1, 1'b1, 1, 3'b101, "rstpr_pulse");
        step(1'b1, 1'b1, 1, 3'b001, "rstpr_held");
        step(1'b0, 1'b1, 2, 3'b000, "rstpr_reset");
        step(1'b1, 1'b1, 5, 3'b000, "rstpr_restart");
        step(1'b1, 1'b1, 1, 3'b101, "rstpr_pulse2");
        step(1'b1, 1'b0, 5, 3'b001, "rstpr_rel_wait");
        step(1'b1, 1'b0, 4, 3'b000, "rstpr_released");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
